// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared definitions for the GPIO peripheral.
//
// Holds the word-address map of the peripheral and the default data
// width, so the decoder, the read mux and any software-facing model
// agree on one set of numbers.
package gpio_pkg;

  // Default bus / port width.
  localparam int GPIO_WIDTH = 32;

  // Word addresses within the peripheral.
  localparam logic [1:0] GPIO_A_IN1  = 2'd0;  // read gpI1
  localparam logic [1:0] GPIO_A_IN2  = 2'd1;  // read gpI2
  localparam logic [1:0] GPIO_A_OUT1 = 2'd2;  // read/write gpO1
  localparam logic [1:0] GPIO_A_OUT2 = 2'd3;  // read/write gpO2

  // Read-source selector, encoded identically to the word address.
  typedef enum logic [1:0] {
    SEL_IN1  = 2'd0,
    SEL_IN2  = 2'd1,
    SEL_OUT1 = 2'd2,
    SEL_OUT2 = 2'd3
  } gpio_sel_e;

  // True when a bus write at address a targets a writable register.
  function automatic logic gpio_is_writable(input logic [1:0] a);
    return (a == GPIO_A_OUT1) || (a == GPIO_A_OUT2);
  endfunction

endpackage : gpio_pkg

// File: rtl/dreg_en.sv
// dreg_en -- enable-gated D register with synchronous active-high reset.
//
// Reusable library element. Reset has priority over the enable, so a
// write coinciding with reset is discarded and q clears.
//
// Ports:
//   clk  in              rising-edge clock
//   rst  in              synchronous active-high reset, q -> 0
//   en   in              load enable
//   d    in  [WIDTH-1:0] data in
//   q    out [WIDTH-1:0] registered data out
module dreg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : dreg_en

// File: rtl/gpio_ad.sv
// gpio_ad -- address decoder for the GPIO peripheral.
//
// Purely combinational. Qualifies the bus write enable by the word
// address so that only the addressed output register sees a write, and
// passes the address through as the read-mux select.
//
// Ports:
//   A      in  [1:0]  word address
//   WE     in         bus write enable
//   WE1    out        write strobe for output register 1 (address 2)
//   WE2    out        write strobe for output register 2 (address 3)
//   RdSel  out [1:0]  read-mux select
module gpio_ad
  import gpio_pkg::*;
(
  input  logic [1:0] A,
  input  logic       WE,
  output logic       WE1,
  output logic       WE2,
  output logic [1:0] RdSel
);

  // Writes to the input-port addresses produce no strobe at all, which
  // is what makes them silently ignored.
  always_comb begin
    WE1   = WE & (A == GPIO_A_OUT1);
    WE2   = WE & (A == GPIO_A_OUT2);
    RdSel = A;
  end

endmodule : gpio_ad

// File: rtl/gpio_periph.sv
// gpio_periph -- memory-mapped GPIO peripheral.
//
// Two unregistered input ports and two output registers on a 2-bit word
// address. Writes complete on the rising edge that ends the access
// cycle; reads are combinational and return the old register value in
// the same cycle as a write to it.
//
// Address map: 0 = gpI1 (RO), 1 = gpI2 (RO), 2 = gpO1 (RW), 3 = gpO2 (RW).
//
// Ports:
//   clk   in              system clock
//   rst   in              synchronous active-high reset (clears gpO1/gpO2)
//   A     in  [1:0]       word address
//   WE    in              write enable, qualified by A
//   WD    in  [WIDTH-1:0] write data
//   gpI1  in  [WIDTH-1:0] input port 1
//   gpI2  in  [WIDTH-1:0] input port 2
//   RD    out [WIDTH-1:0] read data (combinational)
//   gpO1  out [WIDTH-1:0] output register 1
//   gpO2  out [WIDTH-1:0] output register 2
module gpio_periph
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       A,
  input  logic             WE,
  input  logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] gpI1,
  input  logic [WIDTH-1:0] gpI2,
  output logic [WIDTH-1:0] RD,
  output logic [WIDTH-1:0] gpO1,
  output logic [WIDTH-1:0] gpO2
);

  logic       we1;
  logic       we2;
  logic [1:0] rdsel;

  gpio_ad u_ad (
    .A     (A),
    .WE    (WE),
    .WE1   (we1),
    .WE2   (we2),
    .RdSel (rdsel)
  );

  // Register stage: the only state in the block.
  dreg_en #(.WIDTH(WIDTH)) u_reg1 (
    .clk (clk),
    .rst (rst),
    .en  (we1),
    .d   (WD),
    .q   (gpO1)
  );

  dreg_en #(.WIDTH(WIDTH)) u_reg2 (
    .clk (clk),
    .rst (rst),
    .en  (we2),
    .d   (WD),
    .q   (gpO2)
  );

  // Read path: always drives the selected source, independent of WE.
  always_comb begin
    RD = '0;
    unique case (gpio_sel_e'(rdsel))
      SEL_IN1:  RD = gpI1;
      SEL_IN2:  RD = gpI2;
      SEL_OUT1: RD = gpO1;
      SEL_OUT2: RD = gpO2;
      default:  RD = '0;
    endcase
  end

endmodule : gpio_periph

// File: tb/tb_gpio_periph.sv
module tb_gpio_periph;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   A;
  logic         WE;
  logic [W-1:0] WD;
  logic [W-1:0] gpI1;
  logic [W-1:0] gpI2;
  logic [W-1:0] RD;
  logic [W-1:0] gpO1;
  logic [W-1:0] gpO2;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_periph #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .WE   (WE),
    .WD   (WD),
    .gpI1 (gpI1),
    .gpI2 (gpI2),
    .RD   (RD),
    .gpO1 (gpO1),
    .gpO2 (gpO2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; inputs are driven and outputs sampled on the
  // falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    WE   = 1'b1;
    A    = 2'd2;
    WD   = 32'hFFFF_FFFF;
    gpI1 = '0;
    gpI2 = '0;
    @(negedge clk);

    // Reset held two cycles with a write pending at address 2.
    tick();
    tick();
    chk("rst_gpO1", gpO1, 32'h0);
    chk("rst_gpO2", gpO2, 32'h0);
    #1 chk("rst_RD_A2", RD, 32'h0);
    A = 2'd3;
    #1 chk("rst_RD_A3", RD, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    WE  = 1'b0;

    // Combinational input reads.
    gpI1 = 32'h1234_5678;
    gpI2 = 32'hCAFE_BABE;
    A    = 2'd0;
    #1 chk("rd_in1", RD, 32'h1234_5678);
    A = 2'd1;
    #1 chk("rd_in2", RD, 32'hCAFE_BABE);
    @(negedge clk);

    // Write gpO1; readback in the write cycle shows the old value.
    A  = 2'd2;
    WE = 1'b1;
    WD = 32'hDEAD_BEEF;
    #1 chk("wr1_same_cycle_RD", RD, 32'h0);
    tick();
    WE = 1'b0;
    chk("wr1_gpO1", gpO1, 32'hDEAD_BEEF);
    chk("wr1_gpO2_unchanged", gpO2, 32'h0);
    #1 chk("wr1_RD_A2", RD, 32'hDEAD_BEEF);
    @(negedge clk);

    // Write gpO2.
    A  = 2'd3;
    WE = 1'b1;
    WD = 32'h0000_A5A5;
    #1 chk("wr2_same_cycle_RD", RD, 32'h0);
    tick();
    WE = 1'b0;
    chk("wr2_gpO2", gpO2, 32'h0000_A5A5);
    chk("wr2_gpO1_unchanged", gpO1, 32'hDEAD_BEEF);
    #1 chk("wr2_RD_A3", RD, 32'h0000_A5A5);
    @(negedge clk);

    // Writes to input-port addresses are ignored.
    WE = 1'b1;
    A  = 2'd0;
    WD = 32'h5555_5555;
    tick();
    A = 2'd1;
    tick();
    WE = 1'b0;
    chk("ign_gpO1", gpO1, 32'hDEAD_BEEF);
    chk("ign_gpO2", gpO2, 32'h0000_A5A5);
    A = 2'd0;
    #1 chk("ign_RD_A0", RD, 32'h1234_5678);
    A = 2'd1;
    #1 chk("ign_RD_A1", RD, 32'hCAFE_BABE);
    gpI2 = 32'h0BAD_F00D;
    #1 chk("live_RD_A1", RD, 32'h0BAD_F00D);
    @(negedge clk);

    // WE held high while A changes: each cycle writes only its address.
    WE = 1'b1;
    A  = 2'd2;
    WD = 32'h1111_1111;
    tick();
    A  = 2'd3;
    WD = 32'h2222_2222;
    tick();
    WE = 1'b0;
    chk("sweep_gpO1", gpO1, 32'h1111_1111);
    chk("sweep_gpO2", gpO2, 32'h2222_2222);

    // Back-to-back writes to gpO2: the last one wins.
    WE = 1'b1;
    A  = 2'd3;
    WD = 32'hAAAA_AAAA;
    tick();
    chk("b2b_first", gpO2, 32'hAAAA_AAAA);
    WD = 32'h0F0F_0F0F;
    tick();
    WE = 1'b0;
    chk("b2b_last", gpO2, 32'h0F0F_0F0F);
    chk("b2b_gpO1", gpO1, 32'h1111_1111);

    // Hold for 10 cycles with WE low, A sweeping, WD toggling.
    for (int i = 0; i < 10; i++) begin
      A  = 2'(i % 4);
      WD = 32'hFFFF_0000 ^ 32'(i);
      tick();
      chk($sformatf("hold_gpO2_%0d", i), gpO2, 32'h0F0F_0F0F);
    end
    chk("hold_gpO1", gpO1, 32'h1111_1111);

    // Reset coinciding with a write: reset wins.
    WE = 1'b1;
    A  = 2'd2;
    WD = 32'h0000_0001;
    tick();
    chk("mid_pre_gpO1", gpO1, 32'h0000_0001);
    rst = 1'b1;
    WD  = 32'h0000_0002;
    tick();
    chk("mid_rst_gpO1", gpO1, 32'h0);
    chk("mid_rst_gpO2", gpO2, 32'h0);
    rst = 1'b0;

    // Register is writable again after reset.
    WD = 32'h0000_0003;
    tick();
    WE = 1'b0;
    chk("post_rst_gpO1", gpO1, 32'h0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule : tb_gpio_periph
